// File: rtl/demux_pkg.sv
// Shared definitions for the TDM 1:8 demultiplexer: default slot width,
// derived word width, and the receiver state encoding.
package demux_pkg;

   // Default select/slot counter width and the word width it implies.
   localparam int SEL_W_DEF = 3;
   localparam int N_DEF     = 1 << SEL_W_DEF;

   // Receiver states: waiting for a start of frame, or collecting bits.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   // Plain-vector aliases of the states for legacy-style register coding.
   localparam logic [0:0] ST_IDLE = IDLE;
   localparam logic [0:0] ST_RECV = RECV;

   // Word width for a given slot counter width.
   function automatic int word_width(input int sel_w);
      return 1 << sel_w;
   endfunction

endpackage

// File: rtl/demux_1_8_tdm_slot_counter.sv
// Slot counter: tracks which word position the next accepted bit fills.
// Clear wins over load-one, which wins over increment.
module slot_counter
   import demux_pkg::*;
#(
   parameter int SEL_W = SEL_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load1,
   input  logic             inc,
   output logic [SEL_W-1:0] slot
);

   // Slot register with synchronous reset and prioritised controls.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         slot <= '0;
      end else if (load1) begin
         slot <= SEL_W'(1);
      end else if (inc) begin
         slot <= slot + SEL_W'(1);
      end
   end

endmodule

// File: rtl/demux_1_8_tdm.sv
// Time-division 1:N demultiplexer: reassembles serial bits from a stepped
// N:1 mux into words, aligned by a start-of-frame marker. Mid-frame sof
// aborts the partial word (frame_err) and restarts at slot 0.
module demux_1_8_tdm
   import demux_pkg::*;
#(
   parameter int SEL_W = SEL_W_DEF,
   localparam int N    = 1 << SEL_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_valid,
   input  logic             sof,
   output logic [N-1:0]     dout,
   output logic             dout_valid,
   output logic [SEL_W-1:0] slot,
   output logic             busy,
   output logic             frame_err
);

   logic [0:0]   state;
   logic [N-1:0] frame_buf;
   logic [N-1:0] buf_next;
   logic         acc_sof;
   logic         acc_bit;
   logic         last_bit;
   logic         cnt_clr;
   logic         cnt_load1;
   logic         cnt_inc;

   // Qualified events: sof only counts with din_valid; data bits only
   // count while a frame is open.
   assign acc_sof  = din_valid && sof;
   assign acc_bit  = din_valid && !sof && (state == ST_RECV);
   assign last_bit = acc_bit && (slot == SEL_W'(N - 1));

   assign cnt_clr   = last_bit;
   assign cnt_load1 = acc_sof;
   assign cnt_inc   = acc_bit;

   slot_counter #(
      .SEL_W (SEL_W)
   ) u_slot_counter (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .load1 (cnt_load1),
      .inc   (cnt_inc),
      .slot  (slot)
   );

   // Buffer with the incoming bit merged at the current slot, so the last
   // bit of a frame can be published in the same edge it is accepted.
   always_comb begin
      buf_next       = frame_buf;
      buf_next[slot] = din;
   end

   // FSM, assembly buffer and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         frame_buf  <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (acc_sof) begin
            // New frame; an open frame is abandoned and flagged.
            frame_buf <= {{(N-1){1'b0}}, din};
            state     <= ST_RECV;
            if (state == ST_RECV) begin
               frame_err <= 1'b1;
            end
         end else if (acc_bit) begin
            frame_buf <= buf_next;
            if (last_bit) begin
               dout       <= buf_next;
               dout_valid <= 1'b1;
               state      <= ST_IDLE;
            end
         end
      end
   end

   // busy is decoded straight from the state register.
   assign busy = (state == ST_RECV);

endmodule

// File: tb/tb_demux_1_8_tdm.sv
// Self-checking bench for demux_1_8_tdm: directed scenarios plus random
// traffic, every cycle compared against a frame-level reference model.
module tb_demux_1_8_tdm;

   localparam int SEL_W = 3;
   localparam int N     = 1 << SEL_W;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             din = 1'b0;
   logic             din_valid = 1'b0;
   logic             sof = 1'b0;
   logic [N-1:0]     dout;
   logic             dout_valid;
   logic [SEL_W-1:0] slot;
   logic             busy;
   logic             frame_err;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   int fe_cnt = 0;
   int dv_cnt = 0;

   // Reference model state: frame open flag, bits gathered so far, and
   // the word built from them by place value.
   bit           m_open = 0;
   int           m_cnt  = 0;
   logic [N-1:0] m_word = '0;
   logic [N-1:0] m_dout = '0;
   bit           m_dv   = 0;
   bit           m_fe   = 0;

   demux_1_8_tdm #(.SEL_W(SEL_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .sof        (sof),
      .dout       (dout),
      .dout_valid (dout_valid),
      .slot       (slot),
      .busy       (busy),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
      end
   endtask

   // Drive one cycle, advance the model on the edge, compare 1ns later.
   task automatic step(input logic r, input logic dv, input logic d, input logic s);
      rst = r; din_valid = dv; din = d; sof = s;
      @(posedge clk);
      cycle++;
      m_dv = 0;
      m_fe = 0;
      if (r) begin
         m_open = 0; m_cnt = 0; m_word = '0; m_dout = '0;
      end else if (dv) begin
         if (s) begin
            m_fe   = m_open;
            m_open = 1;
            m_cnt  = 1;
            m_word = N'(d);
         end else if (m_open) begin
            m_word = m_word | (N'(d) << m_cnt);
            m_cnt++;
            if (m_cnt == N) begin
               m_dout = m_word;
               m_dv   = 1;
               m_open = 0;
               m_cnt  = 0;
            end
         end
      end
      #1;
      if (dout_valid === 1'b1) dv_cnt++;
      if (frame_err === 1'b1) fe_cnt++;
      chk("dout", 32'(dout), 32'(m_dout));
      chk("dout_valid", 32'(dout_valid), 32'(m_dv));
      chk("slot", 32'(slot), 32'(m_cnt));
      chk("busy", 32'(busy), 32'(m_open));
      chk("frame_err", 32'(frame_err), 32'(m_fe));
   endtask

   // Serialise a word LSB first with sof on bit 0; optional gaps after
   // the slots flagged in gap_mask, with junk on din/sof while invalid.
   task automatic send_frame(input logic [N-1:0] w, input logic [N-1:0] gap_mask, input int gap_len);
      logic [N-1:0] v;
      v = w;
      for (int k = 0; k < N; k++) begin
         step(1'b0, 1'b1, v[k], k == 0);
         if (gap_mask[k] && k < N - 1) begin
            for (int g = 0; g < gap_len; g++) begin
               step(1'b0, 1'b0, 1'($urandom), 1'($urandom));
               chk("gap_slot", 32'(slot), 32'(k + 1));
               chk("gap_busy", 32'(busy), 32'd1);
            end
         end
      end
   endtask

   initial begin
      int t1;
      int fe0;
      int dv0;
      logic [N-1:0] v;

      // Reset state.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_slot", 32'(slot), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      // Basic frame.
      send_frame(8'hAD, '0, 0);
      chk("basic_dout", 32'(dout), 32'hAD);
      chk("basic_dv", 32'(dout_valid), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("basic_dv_pulse", 32'(dout_valid), 32'd0);
      chk("basic_hold", 32'(dout), 32'hAD);

      // Gapped input: 3 idle cycles after slots 2 and 5.
      send_frame(8'hAD, 8'b0010_0100, 3);
      chk("gap_dout", 32'(dout), 32'hAD);
      chk("gap_dv", 32'(dout_valid), 32'd1);

      // Back-to-back frames.
      send_frame(8'hAD, '0, 0);
      t1 = cycle;
      chk("b2b_first", 32'(dout), 32'hAD);
      send_frame(8'h5A, '0, 0);
      chk("b2b_second", 32'(dout), 32'h5A);
      chk("b2b_spacing", 32'(cycle - t1), 32'(N));

      // Mid-frame sof: four bits, then a full frame whose sof aborts them.
      fe0 = fe_cnt;
      dv0 = dv_cnt;
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'($urandom), k == 0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      chk("mid_fe", 32'(frame_err), 32'd1);
      chk("mid_slot", 32'(slot), 32'd1);
      v = 8'h3C;
      for (int k = 1; k < N; k++) step(1'b0, 1'b1, v[k], 1'b0);
      chk("mid_dout", 32'(dout), 32'h3C);
      chk("mid_fe_count", 32'(fe_cnt - fe0), 32'd1);
      chk("mid_dv_count", 32'(dv_cnt - dv0), 32'd1);

      // Mid-frame sof exactly on the last slot.
      send_frame(8'hFF, '0, 0);
      for (int k = 0; k < N - 1; k++) step(1'b0, 1'b1, 1'b1, k == 0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      chk("last_slot_fe", 32'(frame_err), 32'd1);
      chk("last_slot_no_dv", 32'(dout_valid), 32'd0);
      chk("last_slot_keep", 32'(dout), 32'hFF);
      step(1'b1, 1'b0, 1'b0, 1'b0);

      // Reset mid-frame, then unframed bits are ignored.
      send_frame(8'hC3, '0, 0);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'($urandom), k == 0);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk("rstmid_dout", 32'(dout), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_fe", 32'(frame_err), 32'd0);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'($urandom), 1'b0);
      chk("rstmid_idle_slot", 32'(slot), 32'd0);
      send_frame(8'hAD, '0, 0);
      chk("rstmid_dout_after", 32'(dout), 32'hAD);

      // Ignored idle bits.
      for (int k = 0; k < 8; k++) step(1'b0, 1'b1, k[0], 1'b0);
      chk("idle_slot", 32'(slot), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      // Random traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 3) != 0),
              1'($urandom),
              ($urandom_range(0, 11) == 0));
      end
      for (int k = 0; k < 20; k++) begin
         send_frame(N'($urandom), N'($urandom), $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/demux_1_8_tdm.md
# demux_1_8_tdm

Time-division 1:8 demultiplexer: the receive end of a serial link driven by the team's 8:1 mux (MUX_8_1) with its select stepped 0..7. It takes one bit per accepted cycle, steers each bit into the word position given by an internal slot counter, and presents the reassembled 8-bit word with a one-cycle valid strobe. Frame alignment comes from a start-of-frame marker. Misaligned frames are flagged.

## Interface
- SEL_W, 3, select/slot counter width; word width N = 2**SEL_W (8 at default)
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  reset: synchronous, active-high
- din  input  1  serial data bit, equivalent to the mux output Y
- din_valid  input  1  din is meaningful this cycle; bit accepted only when high
- sof  input  1  start of frame; qualified by din_valid; marks the bit as slot 0
- dout  output  N  reassembled word; dout[k] = bit received in slot k
- dout_valid  output  1  one-cycle strobe: dout updated with a complete frame
- slot  output  SEL_W  slot index the next accepted bit will fill (mirrors the mux select s)
- busy  output  1  frame in progress (state RECV)
- frame_err  output  1  one-cycle strobe: frame aborted by sof arriving mid-frame

## Operation
- States: IDLE, RECV.
- IDLE:
  - Bits with din_valid=1, sof=0 are ignored.
  - din_valid=1 with sof=1: store din into shift-buffer bit 0, set slot=1, go to RECV.
- RECV, din_valid=1, sof=0: store din into buffer bit [slot] and increment slot.
- RECV, din_valid=1, sof=0, slot==N-1 (last bit of the frame):
  - Store the bit.
  - Copy the full buffer (including this bit) to dout.
  - Pulse dout_valid.
  - Set slot=0 and go to IDLE.
- RECV, din_valid=0: hold all state. Gaps of any length are allowed.
- RECV, din_valid=1, sof=1, any slot (including N-1): mid-frame sof.
  - Pulse frame_err.
  - Discard the partial buffer; dout is not updated and there is no dout_valid.
  - Treat the bit as slot 0 of a new frame: buffer bit 0 = din, slot=1, stay in RECV.
- Slot arithmetic is modulo N. Slot wrap happens only through frame completion, never by overflow.
- Buffer bits beyond the current slot are don't-care internally. dout always carries a complete frame.

## Timing
- Reset values:
  - Outputs: dout=0, dout_valid=0, slot=0, busy=0, frame_err=0.
  - State: state=IDLE, buffer=0.
- All outputs are registered. No combinational path from any input to any output.
- Latency: dout/dout_valid assert in the cycle after the edge that accepts the slot N-1 bit. With no gaps, that is N cycles after sof is accepted.
- dout_valid and frame_err are high for exactly one cycle. dout holds its value until the next completed frame.
- Back-to-back frames: sof may arrive the cycle immediately after the last bit. This gives continuous throughput of one word per N cycles.
- rst mid-frame: on the next edge, return to IDLE with reset values. The partial frame is lost and no frame_err is raised. Inputs sampled in the reset cycle are ignored.
- Each cycle, slot equals the mux select value the transmitter must present for the next bit.

## Structure
- Shared package demux_pkg holds:
  - the SEL_W default (3) and the derived N;
  - the state enum {IDLE, RECV}.
- One sub-module, slot_counter: SEL_W-bit counter with inputs clr, load1, inc, and output slot. The top level holds the FSM, the buffer, and the output registers.
- Implementation target: roughly 150-250 lines total.

## Test plan
- Basic frame: I=8'b10101101 serialised with s=000..111, so din=1,0,1,1,0,1,0,1 with sof on the first bit and din_valid continuous -> one cycle after the 8th bit, dout=8'hAD, dout_valid=1 for one cycle, frame_err=0.
- Gapped input: same frame with din_valid low for 3 cycles after slots 2 and 5 -> dout=8'hAD; slot holds at 3 and 6 during the gaps; busy=1 throughout.
- Back-to-back frames: 8'hAD then 8'h5A with no idle cycle -> dout_valid pulses exactly 8 cycles apart, carrying 8'hAD then 8'h5A.
- Mid-frame sof: sof reasserted on the 5th bit of a frame, then a full 8'h3C frame -> frame_err pulses once on that bit; no dout_valid for the aborted frame; next dout=8'h3C.
- Reset mid-frame: rst high for one cycle after 4 bits -> all outputs reset, state IDLE. Bits received without sof are then ignored (slot stays 0). A later full frame of 8'hAD yields dout=8'hAD.
- Ignored idle bits: din toggling with din_valid=1, sof=0 while in IDLE -> slot=0, busy=0, no dout_valid, no frame_err.
